// File: rtl/uart_pkg.sv
// Definitions shared between the UART command slave and the UART master:
// FSM encoding, command-byte layout and parity mode.
package uart_pkg;

    typedef enum logic [3:0] {
        IDLE, RX_CMD, RX_DATA, WRITE, READ_REQ, READ_CAP,
        TX_GAP, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } state_t;

    localparam int   RW_BIT     = 7;     // command bit: 1 = write, 0 = read
    localparam logic PARITY_ODD = 1'b0;  // 0 selects even parity

    function automatic logic par_bit(input logic [7:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchroniser, start validation, centre sampling,
// parity and stop check. Held idle whenever arm is low.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int BR = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       arm,
    output logic       active,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int CW = (BR > 1) ? $clog2(BR) : 1;
    localparam int IW = $clog2(8);
    localparam logic [CW-1:0] CNT_LAST = CW'(BR - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BR / 2 - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rstate_t;

    rstate_t       rs;
    logic          s1, s2, s_prev;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          par_bad;
    logic          samp;

    // start bit is checked half a period in, every later bit a full period on
    assign samp   = (rs == R_START) ? (cnt == CNT_HALF) : (cnt == CNT_LAST);
    assign active = (rs != R_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            s_prev     <= 1'b1;
            rs         <= R_IDLE;
            cnt        <= '0;
            idx        <= '0;
            par_bad    <= 1'b0;
            byte_data  <= '0;
            byte_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            s1         <= rx;
            s2         <= s1;
            s_prev     <= s2;
            byte_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (!arm) begin
                rs  <= R_IDLE;
                cnt <= '0;
            end else if (rs == R_IDLE) begin
                cnt <= '0;
                idx <= '0;
                if (s_prev && !s2) rs <= R_START;
            end else begin
                cnt <= samp ? '0 : cnt + 1'b1;
                if (samp) begin
                    case (rs)
                        R_START: rs <= s2 ? R_IDLE : R_DATA;
                        R_DATA: begin
                            byte_data <= {s2, byte_data[7:1]};
                            idx       <= idx + 1'b1;
                            if (idx == IW'(7)) rs <= R_PAR;
                        end
                        R_PAR: begin
                            par_bad <= (s2 != par_bit(byte_data));
                            rs      <= R_STOP;
                        end
                        R_STOP: begin
                            rs <= R_IDLE;
                            // a bad stop outranks parity so only one error fires
                            if (!s2)          frame_err  <= 1'b1;
                            else if (par_bad) parity_err <= 1'b1;
                            else              byte_vld   <= 1'b1;
                        end
                        default: rs <= R_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/uart_cmd_slave.sv
// UART command slave: decodes read/write command frames into register
// strobes and serialises read data back on tx (half-duplex).
module uart_cmd_slave
    import uart_pkg::*;
#(
    parameter int BR           = 434,
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 8,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  tx,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr_en,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  err_parity,
    output logic                  err_frame,
    output logic                  busy
);
    localparam int CW  = (BR > 1) ? $clog2(BR) : 1;
    localparam int IW  = $clog2(8);
    localparam int TMO = TIMEOUT_BITS * BR;
    localparam int TW  = $clog2(TMO);
    localparam logic [CW-1:0] CNT_LAST = CW'(BR - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [TW-1:0] tmo;
    logic [7:0]    tx_sh;
    logic          tx_par;
    logic          cnt_end, tx_phase, arm;
    logic          rx_active, rx_vld, rx_perr, rx_ferr;
    logic [7:0]    rx_data;

    assign busy     = (state != IDLE);
    assign arm      = (state == IDLE) || (state == RX_CMD) || (state == RX_DATA);
    assign cnt_end  = (cnt == CNT_LAST);
    assign tx_phase = state inside {TX_GAP, TX_START, TX_DATA, TX_PARITY, TX_STOP};

    uart_rx_byte #(.BR(BR)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .arm        (arm),
        .active     (rx_active),
        .byte_vld   (rx_vld),
        .byte_data  (rx_data),
        .parity_err (rx_perr),
        .frame_err  (rx_ferr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx          <= 1'b1;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_en   <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            cnt         <= '0;
            idx         <= '0;
            tmo         <= '0;
            tx_sh       <= '0;
            tx_par      <= 1'b0;
        end else begin
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            err_parity <= rx_perr;
            err_frame  <= rx_ferr;
            cnt        <= (tx_phase && !cnt_end) ? cnt + 1'b1 : '0;
            case (state)
                IDLE: if (rx_active) state <= RX_CMD;
                RX_CMD: begin
                    if (rx_vld) begin
                        reg_addr  <= ADDR_WIDTH'(rx_data[RW_BIT-1:0]);
                        reg_rd_en <= !rx_data[RW_BIT];
                        tmo       <= '0;
                        state     <= rx_data[RW_BIT] ? RX_DATA : READ_REQ;
                    end else if (rx_perr || rx_ferr || !rx_active) begin
                        state <= IDLE;
                    end
                end
                RX_DATA: begin
                    if (rx_vld) begin
                        reg_wr_en   <= 1'b1;
                        reg_wr_data <= DATA_WIDTH'(rx_data);
                        state       <= WRITE;
                    end else if (rx_perr || rx_ferr) begin
                        state <= IDLE;
                    end else if (rx_active) begin
                        tmo <= '0;
                    end else if (tmo == TMO_LAST) begin
                        err_frame <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                WRITE:    state <= IDLE;
                READ_REQ: state <= READ_CAP;
                READ_CAP: begin
                    tx_sh  <= 8'(reg_rd_data);
                    tx_par <= par_bit(8'(reg_rd_data));
                    state  <= TX_GAP;
                end
                // tx changes on the same edge as the state, so each phase holds BR cycles
                TX_GAP: if (cnt_end) begin
                    tx    <= 1'b0;
                    state <= TX_START;
                end
                TX_START: if (cnt_end) begin
                    tx    <= tx_sh[0];
                    idx   <= '0;
                    state <= TX_DATA;
                end
                TX_DATA: if (cnt_end) begin
                    idx   <= idx + 1'b1;
                    tx_sh <= tx_sh >> 1;
                    if (idx == IW'(7)) begin
                        tx    <= tx_par;
                        state <= TX_PARITY;
                    end else begin
                        tx <= tx_sh[1];
                    end
                end
                TX_PARITY: if (cnt_end) begin
                    tx    <= 1'b1;
                    state <= TX_STOP;
                end
                TX_STOP: if (cnt_end) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Directed bench for uart_cmd_slave at BR=8: write, read response, parity,
// stop and timeout errors, false start, reset during a response.
module tb_uart_cmd_slave;
    localparam int BR = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       tx;
    logic [6:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data = 8'hA5;
    logic       err_parity, err_frame, busy;

    uart_cmd_slave #(.BR(BR), .ADDR_WIDTH(7), .DATA_WIDTH(8), .TIMEOUT_BITS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .tx          (tx),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         wr_n = 0, rd_n = 0, pe_n = 0, fe_n = 0, wr_cyc = 0, rd_cyc = 0;
    logic [7:0] wr_a = '0, wr_d = '0, rd_a = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (reg_wr_en)  begin wr_n <= wr_n + 1; wr_cyc <= cyc; wr_a <= {1'b0, reg_addr}; wr_d <= reg_wr_data; end
            if (reg_rd_en)  begin rd_n <= rd_n + 1; rd_cyc <= cyc; rd_a <= {1'b0, reg_addr}; end
            if (err_parity) pe_n <= pe_n + 1;
            if (err_frame)  fe_n <= fe_n + 1;
        end
    end

    int n_vec = 0, n_bad = 0;
    int t0 = 0;
    int w0, r0, p0, f0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        w0 = wr_n; r0 = rd_n; p0 = pe_n; f0 = fe_n;
    endtask

    task automatic send(input logic [7:0] b, input logic par_flip, input logic stop_v);
        logic [10:0] fr;
        fr = {stop_v, (^b) ^ par_flip, b, 1'b0};
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < 11; i++) begin
            rx = fr[i];
            repeat (BR) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_tx_low(output int n);
        n = 0;
        while (tx === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic rx_resp(input logic [7:0] b);
        int n, lo;
        wait_tx_low(n);
        chk("tx_start_seen", n < 300, 1);
        chk("rd_to_start", cyc - rd_cyc, 10);
        chk("busy_in_tx", busy, 1);
        lo = 0;
        while (tx === 1'b0 && lo < 20) begin
            @(negedge clk);
            lo++;
        end
        chk("start_len", lo, 8);
        repeat (4) @(negedge clk);
        chk("tx_bit0", tx, b[0]);
        for (int i = 1; i < 8; i++) begin
            repeat (BR) @(negedge clk);
            chk($sformatf("tx_bit%0d", i), tx, b[i]);
        end
        repeat (BR) @(negedge clk);
        chk("tx_parity", tx, ^b);
        repeat (BR) @(negedge clk);
        chk("tx_stop", tx, 1);
        repeat (BR) @(negedge clk);
        chk("busy_after_tx", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wr_data, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_rd_en", reg_rd_en, 0);
        chk("rst_err_p", err_parity, 0);
        chk("rst_err_f", err_frame, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // write 0x3C to address 0x05
        snap();
        send(8'h85, 1'b0, 1'b1);
        send(8'h3C, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("wr_count", wr_n - w0, 1);
        chk("wr_addr", wr_a, 8'h05);
        chk("wr_data", wr_d, 8'h3C);
        chk("wr_latency", wr_cyc - t0, 88);
        chk("wr_no_rd", rd_n - r0, 0);
        chk("wr_no_err", (pe_n - p0) + (fe_n - f0), 0);
        chk("wr_busy", busy, 0);

        // read address 0x12, response 0xA5
        snap();
        send(8'h12, 1'b0, 1'b1);
        rx_resp(8'hA5);
        chk("rd_count", rd_n - r0, 1);
        chk("rd_addr", rd_a, 8'h12);
        chk("rd_addr_held", reg_addr, 7'h12);
        chk("rd_no_wr", wr_n - w0, 0);

        // parity error on a write command
        snap();
        send(8'h85, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("par_err_count", pe_n - p0, 1);
        chk("par_no_frame", fe_n - f0, 0);
        chk("par_no_strobe", (wr_n - w0) + (rd_n - r0), 0);
        chk("par_busy", busy, 0);

        // low stop bit on a read command
        snap();
        send(8'h12, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("stop_err_count", fe_n - f0, 1);
        chk("stop_no_par", pe_n - p0, 0);
        chk("stop_no_strobe", (wr_n - w0) + (rd_n - r0), 0);
        chk("stop_busy", busy, 0);

        // write command then silence: timeout after 32 bit periods
        snap();
        send(8'h85, 1'b0, 1'b1);
        repeat (250) @(negedge clk);
        chk("tmo_not_early", fe_n - f0, 0);
        repeat (50) @(negedge clk);
        chk("tmo_err_count", fe_n - f0, 1);
        chk("tmo_no_wr", wr_n - w0, 0);
        chk("tmo_busy", busy, 0);

        // 3-cycle glitch is a false start
        snap();
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_no_err", (pe_n - p0) + (fe_n - f0), 0);
        chk("glitch_no_strobe", (wr_n - w0) + (rd_n - r0), 0);
        chk("glitch_busy", busy, 0);

        // reset in the middle of a response, then a clean read
        send(8'h12, 1'b0, 1'b1);
        wait_tx_low(n);
        chk("rst_tx_start_seen", n < 300, 1);
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        snap();
        send(8'h12, 1'b0, 1'b1);
        rx_resp(8'hA5);
        chk("rerd_count", rd_n - r0, 1);
        chk("rerd_addr", rd_a, 8'h12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
